// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffer pipeline register with registered in_ready, flush and bubble counting.
// The main entry drives the outputs. The skid entry absorbs one instruction that arrives while downstream stalls.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic in_xfer;
    logic out_xfer;
    logic in_ready_nxt;
    logic out_valid_nxt;
    logic load_main;
    logic load_skid;
    logic move_skid;
    logic clear_main;

    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // State register; handshake outputs are flopped alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    // Next-state logic; flush overrides every transfer
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: if (in_xfer) state_nxt = S_ONE;
                S_ONE: begin
                    if (in_xfer && !out_xfer)      state_nxt = S_TWO;
                    else if (!in_xfer && out_xfer) state_nxt = S_EMPTY;
                end
                S_TWO:   if (out_xfer) state_nxt = S_ONE;
                default: state_nxt = S_EMPTY;
            endcase
        end
    end

    // Output logic: next handshake values and datapath load enables
    always_comb begin
        in_ready_nxt  = (state_nxt != S_TWO);
        out_valid_nxt = (state_nxt != S_EMPTY);
        load_main     = 1'b0;
        load_skid     = 1'b0;
        move_skid     = 1'b0;
        clear_main    = 1'b0;
        if (flush) begin
            clear_main = 1'b1;
        end else begin
            case (state)
                S_EMPTY: load_main = in_xfer;
                S_ONE: begin
                    load_main  = in_xfer & out_xfer;
                    load_skid  = in_xfer & ~out_xfer;
                    clear_main = out_xfer & ~in_xfer;
                end
                S_TWO:   move_skid = out_xfer;
                default: clear_main = 1'b1;
            endcase
        end
    end

    // Main and skid entries; ctrl is zeroed whenever the main entry goes empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_ctrl  <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            if (clear_main) begin
                out_ctrl <= '0;
            end else if (load_main) begin
                out_data <= in_data;
                out_ctrl <= in_ctrl;
            end else if (move_skid) begin
                out_data <= skid_data;
                out_ctrl <= skid_ctrl;
            end
            if (flush) begin
                skid_ctrl <= '0;
            end else if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    // Saturating count of cycles where downstream was ready but got a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!out_valid && out_ready && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 96, width of the datapath payload (operands, immediate, register addresses).
REQ-002 Parameter CTRL_W, default 16, width of the control payload (mem/regwrite strobes, ALU op, mux selects).
REQ-003 Parameter CNT_W, default 16, width of the bubble counter.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 flush  in  1  synchronous kill of all held and incoming instructions.
REQ-007 in_valid  in  1  upstream stage presents an instruction.
REQ-008 in_ready  out  1  stage can accept an instruction this cycle.
REQ-009 in_data  in  DATA_W  upstream datapath payload.
REQ-010 in_ctrl  in  CTRL_W  upstream control payload.
REQ-011 out_valid  out  1  stage presents an instruction downstream.
REQ-012 out_ready  in  1  downstream accepts this cycle.
REQ-013 out_data  out  DATA_W  registered datapath payload.
REQ-014 out_ctrl  out  CTRL_W  registered control payload.
REQ-015 bubble_cnt  out  CNT_W  count of bubbles delivered downstream.

Function
REQ-016 The stage SHALL be a 2-entry skid buffer (main entry drives outputs, skid entry holds overflow), with states EMPTY, ONE, TWO.
REQ-017 Input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; output transfer on out_valid=1 and out_ready=1.
REQ-018 in_ready SHALL be a register output, 1 in EMPTY and ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-019 out_valid SHALL be 1 exactly in ONE and TWO; out_data/out_ctrl SHALL come directly from main-entry flops.
REQ-020 Transitions: EMPTY+in -> ONE; ONE+in+out -> ONE (main reloaded); ONE+in, no out -> TWO (input to skid); ONE+out, no in -> EMPTY; TWO+out -> ONE (skid moves to main); TWO, no out -> TWO; all else hold.
REQ-021 Latency SHALL be 1 cycle (accept at edge N, out_valid at N+1); sustained throughput 1 per cycle with out_ready=1.
REQ-022 Ordering SHALL be strict FIFO; no instruction duplicated or dropped except by flush.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_ctrl SHALL remain stable.
REQ-024 out_ctrl SHALL be all-zero whenever out_valid=0 (bubble carries no write strobes).
REQ-025 flush SHALL take priority over all transfers: next state EMPTY, both entries invalid, main ctrl zeroed, an input presented in the same cycle discarded, in_ready=1 next cycle.
REQ-026 On flush, data payload flops need not be cleared; only valid and ctrl bits are required zero.
REQ-027 bubble_cnt SHALL increment by 1 on each cycle with out_valid=0, out_ready=1 and rst=0, saturating at 2^CNT_W-1.
REQ-028 flush SHALL NOT clear bubble_cnt.

Reset
REQ-029 While rst=1: state EMPTY, out_valid=0, in_ready=1, out_data=0, out_ctrl=0, skid entry=0, bubble_cnt=0; inputs ignored.
REQ-030 rst assertion mid-operation SHALL discard both held entries immediately without waiting for a clock edge.
REQ-031 First transfer SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-032 Streaming: out_ready=1, in_valid=1 with in_data=1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, in_ready constant 1.
REQ-033 Backpressure: send A=0xA, B=0xB with out_ready=0 -> state TWO, in_ready=0, out_data=0xA stable; raise out_ready -> 0xA then 0xB on consecutive cycles, in_ready returns 1.
REQ-034 Flush in TWO with in_valid=1, in_ctrl=0xFFFF -> next cycle out_valid=0, out_ctrl=0, in_ready=1; neither held entry nor incoming one ever appears.
REQ-035 Bubble counting: CNT_W=2, out_ready=1, in_valid=0 for 5 cycles -> bubble_cnt 1,2,3,3,3.
REQ-036 Async reset in ONE between edges -> out_valid=0, out_ctrl=0, bubble_cnt=0 before next edge; transfer accepted on first edge after release.
